point_scalar_mult_ladder: RTL
=============================

Name: point_scalar_mult_ladder

Overview:
- Parametrised successor to the fixed 256-bit scalar-multiplication core.
- Computes R = d·P by sequencing ADD and DBL requests to an external group-operation unit (affine point adder/doubler) over a req/ack port.
- Adds several features:
  - valid/ready in/out handshakes;
  - runtime choice of Montgomery ladder (constant-op-count) or double-and-add;
  - point-at-infinity tracking;
  - local shortcuts for identity operands.
- Sits between the signing/ECDH controllers and the shared field-arithmetic datapath.

Parameters:
- WIDTH, 256, coordinate width in bits.
- SCALAR_BITS, 256, scalar width in bits; sets the bit-counter range.
- CNT_W, $clog2(SCALAR_BITS), bit-index counter width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  job request.
- in_ready  out  1  high only in IDLE.
- px, py  in  WIDTH  base point, captured on in_valid&in_ready.
- d  in  SCALAR_BITS  scalar, captured with px/py.
- ladder  in  1  captured with px/py. 1 = Montgomery ladder; 0 = double-and-add.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed.
- rx, ry  out  WIDTH  result coordinates. Zero when rinf = 1.
- rinf  out  1  result is point at infinity.
- op_req  out  1  group-op request.
- op_dbl  out  1  0 = ADD(A,B), 1 = DBL(A).
- op_ax, op_ay, op_bx, op_by  out  WIDTH  operands. B is don't-care for DBL.
- op_ack  in  1  one-cycle result strobe.
- op_rx, op_ry  in  WIDTH  result.
- op_inf  in  1  result is infinity.

Behaviour:
- Reset values:
  - in_ready = 1 once in IDLE. All other outputs are 0, including out_valid, op_req, rx, ry, rinf.
  - Reset mid-job abandons the job and drops op_req the next cycle. A late op_ack in IDLE is ignored.
- Registers: R0 = (x, y, inf) and R1 = (x, y, inf), plus bit index i (CNT_W bits) and mode bit.
- State encoding lives in the package. States: IDLE, STEP, ADD, DBL, DONE.
- IDLE → STEP on in_valid&in_ready. Capture inputs; set i = SCALAR_BITS-1.
  - Ladder mode: R0 = ∞, R1 = P.
  - Double-and-add mode: R0 = ∞.
- STEP: evaluate bit d[i] and choose operands.
  - Ladder, bit = 1: R0 ← R0+R1, then R1 ← 2·R1.
  - Ladder, bit = 0: R1 ← R0+R1, then R0 ← 2·R0.
  - Double-and-add: R0 ← 2·R0, then, if bit = 1, R0 ← R0+P.
  - Result is always R0.
- Local shortcuts (no op_req issued; one cycle each):
  - ADD with an infinite operand returns the other operand.
  - DBL of ∞ returns ∞.
  - As a consequence, leading scalar zeros issue no requests in either mode.
- ADD/DBL states:
  - Assert op_req with operands stable; hold until op_ack.
  - On the ack cycle, write op_rx/op_ry/op_inf into the destination and deassert op_req the next cycle.
  - Back-to-back requests are allowed: the next op_req may assert the cycle after ack.
  - op_inf = 1 forces the destination inf = 1 and coordinates = 0.
- After the second operation of a bit, or after DBL only for a double-and-add zero bit:
  - If i == 0 → DONE; otherwise i ← i-1 → STEP.
  - i never wraps.
- DONE: out_valid = 1; rx/ry/rinf = R0. Held stable until out_ready; out_valid&out_ready → IDLE.
  - out_ready while not valid is ignored.
  - in_valid during busy is not accepted (in_ready = 0).
- d = 0: no requests issued; result is rinf = 1.
- Latency: SCALAR_BITS STEP cycles, plus 1 cycle per local shortcut, plus (1 + ack wait) per issued operation.

Decomposition:
- Package ecc_pkg holds:
  - state enum;
  - point struct {x, y, inf} parametrised by WIDTH via localparam;
  - OP_ADD/OP_DBL constants.
- One natural sub-module, ladder_operand_mux (combinational): selects op A/B sources and the write-back destination from state, mode and bit.
- The group-op unit itself is external; the bench supplies a behavioural model.

Test Plan:
- Bench model for all scenarios:
  - WIDTH = 8, SCALAR_BITS = 8.
  - Group is Z_97×Z_97 componentwise: ADD = (x1+x2, y1+y2) mod 97; DBL = (2x, 2y) mod 97.
  - op_inf = 1 when the result is (0, 0).
  - op_ack delay is 3 cycles.
- Ladder, P = (3,5), d = 10 → rx = 30, ry = 50, rinf = 0; exactly 7 op_req rising edges.
- Double-and-add, same P and d → (30,50); exactly 4 requests (DBL, DBL, ADD, DBL).
- d = 0 (both modes) → rinf = 1, rx = ry = 0, zero requests. d = 1, ladder → (3,5), exactly 1 DBL request.
- d = 97, P = (3,5), ladder → model returns op_inf on the final ADD; result rinf = 1.
- Handshake stress:
  - hold out_ready = 0 for 20 cycles → out_valid and rx/ry stable, in_ready = 0;
  - pulse in_valid while busy → ignored;
  - random 0–5 cycle ack delays → same results.
- Reset mid-job: assert rst during WAIT of the 3rd op → next cycle op_req = 0, out_valid = 0. After release, in_ready = 1; a fresh job with d = 5 → (15,25).

Source files
------------

// File: rtl/point_scalar_mult_ladder_pkg.sv
// Shared types for the scalar-multiplication sequencer: FSM states, operand sources, point record.
// Combinational definitions only; no latency or backpressure of its own.
package ecc_pkg;

    localparam int ECC_WIDTH = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_ADD,
        S_DBL,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SRC_R0,
        SRC_R1,
        SRC_P
    } src_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_DBL = 1'b1;

    typedef struct packed {
        logic [ECC_WIDTH-1:0] x;
        logic [ECC_WIDTH-1:0] y;
        logic                 inf;
    } point_t;

endpackage

// File: rtl/point_scalar_mult_ladder_operand_mux.sv
// Picks group-op operand sources and the write-back register for the current state/mode/scalar bit.
// Purely combinational, zero latency, no backpressure.
module ladder_operand_mux
    import ecc_pkg::*;
(
    input  state_t state,
    input  logic   ladder,
    input  logic   bit_val,
    output src_t   a_sel,
    output src_t   b_sel,
    output logic   dst_r1,
    output logic   op_dbl
);

    always_comb begin
        a_sel  = SRC_R0;
        b_sel  = SRC_R1;
        dst_r1 = 1'b0;
        op_dbl = OP_ADD;
        if (state == S_DBL) begin
            op_dbl = OP_DBL;
            // Ladder doubles the register that did not receive the sum.
            if (ladder && bit_val) begin
                a_sel  = SRC_R1;
                dst_r1 = 1'b1;
            end
        end else if (ladder) begin
            dst_r1 = !bit_val;
        end else begin
            b_sel = SRC_P;
        end
    end

endmodule

// File: rtl/point_scalar_mult_ladder.sv
// R = d*P by sequencing ADD/DBL requests to an external group unit; ladder or double-and-add.
// Latency: one STEP per scalar bit plus per-op cycles; result held until out_ready, input taken only in IDLE.
module point_scalar_mult_ladder
    import ecc_pkg::*;
#(
    parameter int WIDTH       = 256,
    parameter int SCALAR_BITS = 256,
    parameter int CNT_W       = $clog2(SCALAR_BITS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       px,
    input  logic [WIDTH-1:0]       py,
    input  logic [SCALAR_BITS-1:0] d,
    input  logic                   ladder,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       rx,
    output logic [WIDTH-1:0]       ry,
    output logic                   rinf,
    output logic                   op_req,
    output logic                   op_dbl,
    output logic [WIDTH-1:0]       op_ax,
    output logic [WIDTH-1:0]       op_ay,
    output logic [WIDTH-1:0]       op_bx,
    output logic [WIDTH-1:0]       op_by,
    input  logic                   op_ack,
    input  logic [WIDTH-1:0]       op_rx,
    input  logic [WIDTH-1:0]       op_ry,
    input  logic                   op_inf
);

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             inf;
    } pt_t;

    state_t                 state, state_nx;
    pt_t                    r0, r1, p_q, a_pt, b_pt, res;
    logic [SCALAR_BITS-1:0] d_q;
    logic                   mode;
    logic [CNT_W-1:0]       idx;
    logic                   req_q;
    logic                   bit_val, op_st, shortcut, wb, advance;
    src_t                   a_sel, b_sel;
    logic                   dst_r1, dbl;

    assign bit_val = d_q[idx];
    assign op_st   = (state == S_ADD) || (state == S_DBL);

    ladder_operand_mux u_mux (
        .state   (state),
        .ladder  (mode),
        .bit_val (bit_val),
        .a_sel   (a_sel),
        .b_sel   (b_sel),
        .dst_r1  (dst_r1),
        .op_dbl  (dbl)
    );

    always_comb begin
        case (a_sel)
            SRC_R1:  a_pt = r1;
            SRC_P:   a_pt = p_q;
            default: a_pt = r0;
        endcase
        case (b_sel)
            SRC_R0:  b_pt = r0;
            SRC_P:   b_pt = p_q;
            default: b_pt = r1;
        endcase
    end

    // Identity operands resolve locally in one cycle without touching the group unit.
    assign shortcut = (state == S_ADD) ? (a_pt.inf || b_pt.inf) : a_pt.inf;
    assign wb       = op_st && (shortcut || (req_q && op_ack));

    always_comb begin
        res = a_pt;
        if (state == S_ADD && a_pt.inf)
            res = b_pt;
        else if (!shortcut)
            res = op_inf ? '{x: '0, y: '0, inf: 1'b1} : '{x: op_rx, y: op_ry, inf: 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        advance  = 1'b0;
        case (state)
            S_IDLE: if (in_valid) state_nx = S_STEP;
            S_STEP: state_nx = mode ? S_ADD : S_DBL;
            S_ADD: begin
                if (wb) begin
                    if (mode) state_nx = S_DBL;
                    else      advance  = 1'b1;
                end
            end
            S_DBL: begin
                if (wb) begin
                    if (!mode && bit_val) state_nx = S_ADD;
                    else                  advance  = 1'b1;
                end
            end
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (advance) state_nx = (idx == '0) ? S_DONE : S_STEP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r0    <= '0;
            r1    <= '0;
            p_q   <= '0;
            d_q   <= '0;
            mode  <= 1'b0;
            idx   <= '0;
            req_q <= 1'b0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                p_q  <= '{x: px, y: py, inf: 1'b0};
                d_q  <= d;
                mode <= ladder;
                idx  <= CNT_W'(SCALAR_BITS - 1);
                r0   <= '{x: '0, y: '0, inf: 1'b1};
                r1   <= '{x: px, y: py, inf: 1'b0};
            end
            if (wb) begin
                if (dst_r1) r1 <= res;
                else        r0 <= res;
            end
            if (advance && idx != '0) idx <= idx - CNT_W'(1);
            // Request drops the cycle after ack; the next op re-raises it one cycle later.
            req_q <= op_st && !shortcut && !(req_q && op_ack);
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign rx        = (out_valid && !r0.inf) ? r0.x : '0;
    assign ry        = (out_valid && !r0.inf) ? r0.y : '0;
    assign rinf      = out_valid && r0.inf;
    assign op_req    = req_q;
    assign op_dbl    = req_q && dbl;
    assign op_ax     = req_q ? a_pt.x : '0;
    assign op_ay     = req_q ? a_pt.y : '0;
    assign op_bx     = req_q ? b_pt.x : '0;
    assign op_by     = req_q ? b_pt.y : '0;

endmodule
